// File: rtl/comparator_arbiter.sv
// comparator_arbiter
// Shares one registered WIDTH-bit comparator between two requesters.
// Round-robin arbitration picks a winner, captures its operands and mode,
// and one cycle later returns a tagged greater/smaller/equal result.
//
// Handshake: req0/req1 are held high until the matching one-cycle gnt pulse
// is seen; operands are sampled only at the grant edge. res_valid is a
// one-cycle pulse; res_id/res_g/res_s/res_e hold until the next result.
//
// Build option: define CMP_ARB_FIXED_PRIO_EN for fixed priority (req0 always
// wins contention). Undefined (default) gives round-robin.

module comparator_arbiter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             s0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             s1,
    output logic             gnt1,
    output logic             busy,
    output logic             res_valid,
    output logic             res_id,
    output logic             res_g,
    output logic             res_s,
    output logic             res_e,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             grant_any;
    logic             win;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             s_reg;
    logic             id_reg;
    logic             cmp_g;
    logic             cmp_s;
    logic             cmp_e;

`ifndef CMP_ARB_FIXED_PRIO_EN
    logic             last_id;
`endif

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // Winner selection: on contention the requester other than the last one
    // granted wins (or req0 always, in the fixed-priority build).
    always_comb begin
        win = 1'b0;
`ifdef CMP_ARB_FIXED_PRIO_EN
        win = !req0;
`else
        if (req0 && req1) begin
            win = !last_id;
        end else begin
            win = req1;
        end
`endif
    end

    // Next-state logic; a grant may be issued from IDLE or RESP only.
    always_comb begin
        next_state = state;
        grant_any  = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant_any  = 1'b1;
                    next_state = EXEC;
                end
            end
            EXEC: begin
                next_state = RESP;
            end
            RESP: begin
                if (req0 || req1) begin
                    grant_any  = 1'b1;
                    next_state = EXEC;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Comparator on the captured operands, signed or unsigned per s_reg.
    always_comb begin
        cmp_e = (a_reg == b_reg);
        if (s_reg) begin
            cmp_g = ($signed(a_reg) > $signed(b_reg));
        end else begin
            cmp_g = (a_reg > b_reg);
        end
        cmp_s = !cmp_g && !cmp_e;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Grant pulses and operand capture at the grant edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            a_reg  <= '0;
            b_reg  <= '0;
            s_reg  <= 1'b0;
            id_reg <= 1'b0;
        end else begin
            gnt0 <= grant_any && !win;
            gnt1 <= grant_any && win;
            if (grant_any) begin
                a_reg  <= win ? a1 : a0;
                b_reg  <= win ? b1 : b0;
                s_reg  <= win ? s1 : s0;
                id_reg <= win;
            end
        end
    end

`ifndef CMP_ARB_FIXED_PRIO_EN
    // Round-robin pointer: remembers the most recently granted requester.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_id <= 1'b1;
        end else if (grant_any) begin
            last_id <= win;
        end
    end
`endif

    // Result registers: loaded at the end of EXEC, held until the next load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            res_g     <= 1'b0;
            res_s     <= 1'b0;
            res_e     <= 1'b0;
        end else begin
            res_valid <= (state == EXEC);
            if (state == EXEC) begin
                res_id <= id_reg;
                res_g  <= cmp_g;
                res_s  <= cmp_s;
                res_e  <= cmp_e;
            end
        end
    end

endmodule
